// File: rtl/hidden_layer_scheduler.sv
// Time-multiplexed hidden layer: buffers one input frame, then per neuron runs a
// serial MAC against an external weight ROM, clamps, and reads an external sigmoid LUT.
module hidden_layer_scheduler #(
  parameter int NUM_INPUTS  = 37,
  parameter int NUM_NEURONS = 16,
  parameter int SUM_MIN     = -32768,
  parameter int SUM_MAX     = 32767,
  parameter int SIG_LAT     = 2,
  localparam int W_AW       = $clog2(NUM_INPUTS * NUM_NEURONS),
  localparam int N_AW       = $clog2(NUM_NEURONS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  output logic [W_AW-1:0] w_addr,
  input  logic [7:0]      w_data,
  output logic            sig_rd,
  output logic [15:0]     sig_addr,
  input  logic [7:0]      sig_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic [N_AW-1:0] out_index,
  output logic            busy,
  output logic            frame_done
);

  localparam int CNT_W  = $clog2(NUM_INPUTS + SIG_LAT + 1);
  localparam int BUF_AW = $clog2(NUM_INPUTS);
  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(NUM_INPUTS - 1);
  localparam logic [CNT_W-1:0] LAST_SIG = CNT_W'(SIG_LAT - 1);
  localparam logic [N_AW-1:0]  LAST_N   = N_AW'(NUM_NEURONS - 1);
  localparam logic signed [31:0] MIN32 = 32'(SUM_MIN);
  localparam logic signed [31:0] MAX32 = 32'(SUM_MAX);
  localparam logic [15:0] MIN16 = MIN32[15:0];
  localparam logic [15:0] MAX16 = MAX32[15:0];

  typedef enum logic [2:0] {
    S_LOAD, S_MAC, S_DRAIN, S_CLAMP, S_SIG_WAIT, S_OUT, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]   cnt_reg;
  logic [N_AW-1:0]    n_reg;
  logic signed [31:0] acc_reg;
  logic [W_AW-1:0]    w_addr_reg;
  logic [15:0]        sig_addr_reg;
  logic [7:0]         out_data_reg;
  logic [N_AW-1:0]    out_index_reg;

  logic [7:0] buffer [NUM_INPUTS];
  logic [7:0] x_q;

  logic signed [16:0] prod;
  logic signed [31:0] prod_ext;
  logic [15:0]        clamp_lo;
  logic [15:0]        clamp_addr;

  // x_q and w_data both lag their address by one cycle, so they pair up naturally.
  assign prod     = $signed({1'b0, x_q}) * $signed(w_data);
  assign prod_ext = {{15{prod[16]}}, prod};

  // Only the low 16 bits matter once the sum is inside [SUM_MIN, SUM_MAX].
  assign clamp_lo   = (acc_reg < MIN32) ? MIN16 :
                      (acc_reg > MAX32) ? MAX16 : acc_reg[15:0];
  assign clamp_addr = clamp_lo - MIN16;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_LOAD;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_LOAD:     if (in_valid && cnt_reg == LAST_IN) state_next = S_MAC;
      S_MAC:      if (cnt_reg == LAST_IN) state_next = S_DRAIN;
      S_DRAIN:    state_next = S_CLAMP;
      S_CLAMP:    state_next = S_SIG_WAIT;
      S_SIG_WAIT: if (cnt_reg == LAST_SIG) state_next = S_OUT;
      S_OUT:      if (out_ready) state_next = (n_reg == LAST_N) ? S_DONE : S_MAC;
      S_DONE:     state_next = S_LOAD;
      default:    state_next = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready   = (state_reg == S_LOAD);
    busy       = (state_reg != S_LOAD);
    sig_rd     = (state_reg == S_CLAMP);
    out_valid  = (state_reg == S_OUT);
    frame_done = (state_reg == S_DONE);
    sig_addr   = (state_reg == S_CLAMP) ? clamp_addr : sig_addr_reg;
    w_addr     = w_addr_reg;
    out_data   = out_data_reg;
    out_index  = out_index_reg;
  end

  // Input buffer: plain array with registered read so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (state_reg == S_LOAD && in_valid) buffer[cnt_reg[BUF_AW-1:0]] <= in_data;
    x_q <= buffer[cnt_reg[BUF_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      n_reg         <= '0;
      acc_reg       <= '0;
      w_addr_reg    <= '0;
      sig_addr_reg  <= '0;
      out_data_reg  <= '0;
      out_index_reg <= '0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          if (in_valid) begin
            if (cnt_reg == LAST_IN) begin
              cnt_reg    <= '0;
              n_reg      <= '0;
              acc_reg    <= '0;
              w_addr_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        S_MAC: begin
          // Cycle 0 has no product in flight yet.
          if (cnt_reg != '0) acc_reg <= acc_reg + prod_ext;
          if (cnt_reg == LAST_IN) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg    <= cnt_reg + CNT_W'(1);
            w_addr_reg <= w_addr_reg + W_AW'(1);
          end
        end
        S_DRAIN: acc_reg <= acc_reg + prod_ext;
        S_CLAMP: begin
          sig_addr_reg <= clamp_addr;
          cnt_reg      <= '0;
        end
        S_SIG_WAIT: begin
          if (cnt_reg == LAST_SIG) begin
            out_data_reg  <= sig_data;
            out_index_reg <= n_reg;
            cnt_reg       <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_OUT: begin
          // Weight rows are contiguous, so the next neuron starts one past the last address.
          if (out_ready && n_reg != LAST_N) begin
            n_reg      <= n_reg + N_AW'(1);
            w_addr_reg <= w_addr_reg + W_AW'(1);
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        S_DONE: begin
          cnt_reg <= '0;
          n_reg   <= '0;
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_layer_scheduler.sv
// Directed + randomized bench for hidden_layer_scheduler with weight ROM and sigmoid LUT models;
// expected activations come from a plain dot-product/clamp reference.
module tb_hidden_layer_scheduler;

  localparam int NI = 37;
  localparam int NN = 16;
  localparam int LAT = NI + 2 + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [9:0]  w_addr;
  logic [7:0]  w_data = '0;
  logic        sig_rd;
  logic [15:0] sig_addr;
  logic [7:0]  sig_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [3:0]  out_index;
  logic        busy;
  logic        frame_done;

  hidden_layer_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data), .sig_rd(sig_rd), .sig_addr(sig_addr),
    .sig_data(sig_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0]  rom [NI*NN];
  logic [7:0]  xs [NI];
  logic [7:0]  s1 = '0, s2 = '0;
  logic [15:0] sig_q [$];
  int          cyc = 0;
  int          fd_count = 0;
  int          t_entry = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [7:0] sigf(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h5A;
  endfunction

  // Reference: dot product, clamp, offset into LUT address space.
  function automatic int model_addr(input int n);
    int s = 0;
    for (int k = 0; k < NI; k++) s += int'(xs[k]) * int'($signed(rom[n*NI+k]));
    if (s < -32768) s = -32768;
    else if (s > 32767) s = 32767;
    return s + 32768;
  endfunction

  // Weight ROM: one-cycle latency. Sigmoid LUT: two-cycle latency, garbage unless strobed.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    w_data <= rom[w_addr];
    s1     <= sig_rd ? sigf(sig_addr) : ~sigf(sig_addr);
    s2     <= s1;
  end
  assign sig_data = s2;

  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (sig_rd) sig_q.push_back(sig_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) tick();
    rst = 1'b0;
    sig_q.delete();
  endtask

  task automatic fill(input int w, input int x);
    for (int i = 0; i < NI*NN; i++) rom[i] = 8'(w);
    for (int k = 0; k < NI; k++) xs[k] = 8'(x);
  endtask

  task automatic send_beat(input logic [7:0] d);
    int guard = 0;
    while (!in_ready && guard < 1000) begin tick(); guard++; end
    if (guard >= 1000) check("in_ready_timeout", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_frame(input int gap);
    for (int k = 0; k < NI; k++) begin
      if (k == NI-1) check("busy_before_last_beat", 32'(busy), 0);
      send_beat(xs[k]);
      if (k < NI-1) repeat (gap) tick();
    end
    check("busy_after_last_beat", 32'(busy), 1);
    check("in_ready_after_last_beat", 32'(in_ready), 0);
    t_entry = cyc;
  endtask

  task automatic wait_out(output bit ok);
    int guard = 0;
    while (!out_valid && guard < 300) begin tick(); guard++; end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 1);
    ok = out_valid;
  endtask

  task automatic collect(input int first_n, input int last_n, input int stall_n);
    bit ok;
    int ea;
    for (int n = first_n; n <= last_n; n++) begin
      wait_out(ok);
      if (!ok) return;
      ea = model_addr(n);
      check("out_latency", cyc - t_entry, LAT);
      check("out_index", 32'(out_index), n);
      check("out_data", 32'(out_data), 32'(sigf(16'(ea))));
      check("sig_rd_pulses", sig_q.size(), 1);
      if (sig_q.size() > 0) check("sig_addr", 32'(sig_q.pop_front()), ea);
      sig_q.delete();
      $display("neuron %0d: index=%0d data=%0d expected_addr=%0d", n, out_index, out_data, ea);
      if (n == stall_n) begin
        repeat (5) begin
          tick();
          check("stall_out_valid", 32'(out_valid), 1);
          check("stall_out_data", 32'(out_data), 32'(sigf(16'(ea))));
          check("stall_out_index", 32'(out_index), n);
          check("stall_w_addr", 32'(w_addr), n*NI + NI-1);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      t_entry = cyc;
      check("out_valid_drop", 32'(out_valid), 0);
      check("frame_done_timing", 32'(frame_done), (n == NN-1) ? 1 : 0);
    end
  endtask

  initial begin
    bit ok;
    int seen;

    do_reset(3);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sig_rd", 32'(sig_rd), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_w_addr", 32'(w_addr), 0);
    check("rst_sig_addr", 32'(sig_addr), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_index", 32'(out_index), 0);

    // w=1, x=255: sum 9435 -> addr 42203; stall on neuron 2
    fill(1, 255);
    load_frame(0);
    collect(0, NN-1, 2);
    tick();
    check("fd_count_a", fd_count, 1);
    check("in_ready_after_done", 32'(in_ready), 1);
    check("addr_a_ref", model_addr(0), 42203);

    // partial frame aborted by reset, then gapped frame with w=-128 -> addr 0
    fill(-128, 255);
    for (int k = 0; k < 10; k++) send_beat(xs[k]);
    do_reset(1);
    check("mid_load_rst_in_ready", 32'(in_ready), 1);
    check("mid_load_rst_busy", 32'(busy), 0);
    load_frame(2);
    collect(0, NN-1, -1);
    tick();
    check("fd_count_b", fd_count, 2);

    // w=127 -> clamp high, addr 65535
    fill(127, 255);
    load_frame(0);
    collect(0, NN-1, -1);
    tick();
    check("fd_count_c", fd_count, 3);

    // x[k]=k, only neuron 3 has weights -> 32768+666
    fill(0, 0);
    for (int k = 0; k < NI; k++) begin
      xs[k] = 8'(k);
      rom[3*NI+k] = 8'd1;
    end
    load_frame(0);
    collect(0, NN-1, -1);
    tick();
    check("fd_count_d", fd_count, 4);

    // random small weights; reset in the middle of neuron 5's MAC
    for (int i = 0; i < NI*NN; i++) rom[i] = 8'($urandom_range(0, 7) - 4);
    for (int k = 0; k < NI; k++) xs[k] = 8'($urandom_range(0, 255));
    load_frame(1);
    collect(0, 4, -1);
    repeat (10) tick();
    do_reset(1);
    check("mid_mac_rst_out_valid", 32'(out_valid), 0);
    check("mid_mac_rst_busy", 32'(busy), 0);
    check("mid_mac_rst_in_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (60) begin tick(); if (out_valid || frame_done) seen++; end
    check("stale_activity", seen, 0);
    check("fd_count_abort", fd_count, 4);

    // clean random frame after the abort, full-range weights
    for (int i = 0; i < NI*NN; i++) rom[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k < NI; k++) xs[k] = 8'($urandom_range(0, 255));
    load_frame(0);
    collect(0, NN-1, 7);
    tick();
    check("fd_count_f", fd_count, 5);

    // reset while out_valid is high
    for (int i = 0; i < NI*NN; i++) rom[i] = 8'($urandom_range(0, 15) - 8);
    load_frame(0);
    wait_out(ok);
    check("pre_rst_out_index", 32'(out_index), 0);
    do_reset(1);
    check("out_rst_out_valid", 32'(out_valid), 0);
    check("out_rst_in_ready", 32'(in_ready), 1);
    repeat (3) tick();
    check("fd_count_out_rst", fd_count, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
